// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported RAM between the CPU access path
// (port 0) and a loader/debug master (port 1). Each access runs through
// IDLE -> ACCESS (MEM_LATENCY cycles) -> DONE, with a req/ack handshake and
// round-robin or fixed-priority selection when both ports request together.
module mem_port_arbiter #(
  parameter int ADDRESS_SIZE  = 11,
  parameter int WORD_SIZE     = 64,
  parameter int MEM_LATENCY   = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [ADDRESS_SIZE-1:0] p0_addr,
  input  logic [WORD_SIZE-1:0]    p0_wdata,
  output logic                    p0_ack,
  output logic [WORD_SIZE-1:0]    p0_rdata,

  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [ADDRESS_SIZE-1:0] p1_addr,
  input  logic [WORD_SIZE-1:0]    p1_wdata,
  output logic                    p1_ack,
  output logic [WORD_SIZE-1:0]    p1_rdata,

  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic                    ram_is_reading,
  output logic [WORD_SIZE-1:0]    ram_data_in,
  input  logic [WORD_SIZE-1:0]    ram_data_out,

  output logic                    busy,
  output logic                    grant_id
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The down-counter is 4 bits wide, which covers latencies up to 15 cycles.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t                   state_q;
  logic [3:0]               cnt_q;
  logic                     grant_q;
  logic                     last_grant_q;
  logic                     we_q;
  logic [ADDRESS_SIZE-1:0]  addr_q;
  logic [WORD_SIZE-1:0]     wdata_q;
  logic                     ram_is_reading_q;
  logic                     p0_ack_q;
  logic                     p1_ack_q;
  logic [WORD_SIZE-1:0]     p0_rdata_q;
  logic [WORD_SIZE-1:0]     p1_rdata_q;

  logic                     any_req_d;
  logic                     winner_d;
  logic                     win_we_d;
  logic [ADDRESS_SIZE-1:0]  win_addr_d;
  logic [WORD_SIZE-1:0]     win_wdata_d;

  // Arbitration: a lone requester wins; a tie goes to port 0 in fixed mode,
  // otherwise to whichever port did not own the previous access.
  always_comb begin
    any_req_d = p0_req | p1_req;
    winner_d  = 1'b0;
    if (p0_req && p1_req) begin
      winner_d = (PRIORITY_MODE == 1) ? 1'b0 : ~last_grant_q;
    end else if (p1_req) begin
      winner_d = 1'b1;
    end
    win_we_d    = winner_d ? p1_we    : p0_we;
    win_addr_d  = winner_d ? p1_addr  : p0_addr;
    win_wdata_d = winner_d ? p1_wdata : p0_wdata;
  end

  // Access sequencer; the latched request copies drive the RAM pins directly,
  // so the address and write data stay put after ACCESS until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= 4'd0;
      grant_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      we_q             <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      ram_is_reading_q <= 1'b1;
      p0_ack_q         <= 1'b0;
      p1_ack_q         <= 1'b0;
      p0_rdata_q       <= '0;
      p1_rdata_q       <= '0;
    end else begin
      p0_ack_q <= 1'b0;
      p1_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            grant_q          <= winner_d;
            last_grant_q     <= winner_d;
            we_q             <= win_we_d;
            addr_q           <= win_addr_d;
            wdata_q          <= win_wdata_d;
            ram_is_reading_q <= ~win_we_d;
            cnt_q            <= CNT_INIT;
            state_q          <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            if (!we_q) begin
              if (grant_q) begin
                p1_rdata_q <= ram_data_out;
              end else begin
                p0_rdata_q <= ram_data_out;
              end
            end
            if (grant_q) begin
              p1_ack_q <= 1'b1;
            end else begin
              p0_ack_q <= 1'b1;
            end
            ram_is_reading_q <= 1'b1;
            state_q          <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          ram_is_reading_q <= 1'b1;
          state_q          <= IDLE;
        end
      endcase
    end
  end

  assign p0_ack         = p0_ack_q;
  assign p1_ack         = p1_ack_q;
  assign p0_rdata       = p0_rdata_q;
  assign p1_rdata       = p1_rdata_q;
  assign ram_address    = addr_q;
  assign ram_is_reading = ram_is_reading_q;
  assign ram_data_in    = wdata_q;
  assign busy           = (state_q != IDLE);
  assign grant_id       = grant_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the multicycle core's single-ported RAM between two requesters: port 0 is the CPU memory access path (fetch and load/store), port 1 is a program loader/debug master.
- Sits between the requesters and the RAM's address, isReading, dataIn and dataOut pins.
- Serializes accesses through a small FSM with a req/ack handshake, parameterised RAM latency, and round-robin or fixed-priority arbitration.

Parameters:
- ADDRESS_SIZE, 11, RAM word-address width.
- WORD_SIZE, 64, data width.
- MEM_LATENCY, 1, cycles the RAM pins are held per access; legal range 1..15.
- PRIORITY_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed (port 0 always wins ties).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- p0_req  input  1  port 0 access request, held until p0_ack
- p0_we  input  1  port 0 write (1) / read (0)
- p0_addr  input  ADDRESS_SIZE  port 0 address
- p0_wdata  input  WORD_SIZE  port 0 write data
- p0_ack  output  1  one-cycle completion pulse for port 0
- p0_rdata  output  WORD_SIZE  port 0 read data; valid from ack, held until the next port 0 read completes
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1
- ram_address  output  ADDRESS_SIZE  RAM address
- ram_is_reading  output  1  1 = read, 0 = write
- ram_data_in  output  WORD_SIZE  RAM write data
- ram_data_out  input  WORD_SIZE  RAM read data (combinational from ram_address)
- busy  output  1  high whenever state != IDLE
- grant_id  output  1  port owning the current or last access

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - p0_ack = p1_ack = 0; p0_rdata = p1_rdata = 0.
  - ram_is_reading = 1; ram_address = 0; ram_data_in = 0.
  - busy = 0; grant_id = 0.
  - last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high at the clock edge, pick a winner.
  - Round-robin: the sole requester wins; if both request, the port != last_grant wins.
  - Fixed mode: port 0 wins any tie.
  - Latch the winner's addr, we and wdata into internal registers.
  - Set grant_id = last_grant = winner; load cnt = MEM_LATENCY-1; go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - ram_address = latched addr.
  - ram_is_reading = ~latched we.
  - ram_data_in = latched wdata.
  - When cnt == 0: for a read, register ram_data_out into the granted port's rdata; go to DONE.
  - Otherwise decrement cnt.
- DONE:
  - The granted port's ack = 1 for exactly this cycle.
  - ram_is_reading = 1 (RAM returns to read).
  - Go to IDLE.
  - A req still high during DONE is not sampled; requesters drop req in the ack cycle.
- Outside ACCESS: ram_is_reading = 1; ram_address holds its last value.
- Latency: a req sampled at edge T (arbiter in IDLE) gives an ack high during cycle T+MEM_LATENCY+1. Throughput is one access per MEM_LATENCY+2 cycles.
- Write semantics: rdata of the writing port is unchanged by a write; ack still pulses.
- Request stability: req/we/addr/wdata are only sampled in IDLE. Later changes before ack are ignored because accesses use the latched copies.
- Simultaneous requests under round-robin: ports alternate, so neither port waits more than one foreign access.
- Reset mid-access:
  - Aborts immediately; no ack is issued.
  - ram_is_reading = 1 in the cycle after the reset edge; a multi-cycle write in progress is truncated.
- Never drive ram_is_reading = 0 outside ACCESS.
- Never assert both acks in the same cycle.

Test Plan:
- Reset then single read: MEM_LATENCY=1, RAM[5]=64'hDEAD_BEEF; p0 read addr 5 at cycle 0. Required: p0_ack high at cycle 2 only; p0_rdata = 64'hDEAD_BEEF; p1_ack never high.
- Write then read: p1 writes 64'h1234 to addr 10, then p1 reads addr 10. Required: ram_is_reading = 0 only during the write's ACCESS cycle; read returns 64'h1234; p1_rdata unchanged (0) after the write ack.
- Contention, round-robin: both req held continuously, 4 accesses. Required: grant order 0,1,0,1; acks at cycles 2, 5, 8, 11 (MEM_LATENCY=1).
- Fixed priority: PRIORITY_MODE=1, both req held. Required: port 0 granted every time; port 1 is granted only after p0_req drops.
- Latency sweep: MEM_LATENCY=3, p0 read. Required: ack at cycle 4; RAM address stable for 3 cycles; busy high for cycles 1-4.
- Reset mid-access: MEM_LATENCY=4, p1 write starts; reset asserted during the 2nd ACCESS cycle. Required: no p1_ack; ram_is_reading = 1 in the cycle after the reset edge; state IDLE; the next tie goes to port 0.
